puf_multi_sampler: RTL
======================

PUF_MULTI_SAMPLER -- requirements
Module: puf_multi_sampler

Interface
REQ-001 SHALL have parameter NUM_PUF, default 4: number of PUF sources (2..16).
REQ-002 SHALL have parameter RESP_W, default 64: max response bits (multiple of 8, >=8).
REQ-003 SHALL have parameter VOTE, default 3: samples per bit for majority vote (odd, >=1).
REQ-004 SHALL have parameter SETTLE_CYC, default 8: settle cycles before each bit's sampling (>=1).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request a response capture, sampled in IDLE only.
REQ-008 SHALL have port puf_sel  input  SELW=max(1,$clog2(NUM_PUF))  source index.
REQ-009 SHALL have port length  input  2  response length code: L = RESP_W >> (3-length).
REQ-010 SHALL have port puf_bit  input  NUM_PUF  raw response bit per source.
REQ-011 SHALL have port puf_en  output  NUM_PUF  one-hot enable of the selected source.
REQ-012 SHALL have port chal  output  $clog2(RESP_W)  challenge index of the bit being evaluated.
REQ-013 SHALL have port resp  output  RESP_W  parallel response, right-aligned in the low L bits.
REQ-014 SHALL have port so / so_valid  output  1 / 1  serial response, MSB first, with qualifier.
REQ-015 SHALL have ports busy, done, err  output  1 each  status; done and err are one-cycle pulses.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, SAMPLE, SHIFT, DONE.
REQ-017 IDLE with start=1 and puf_sel<NUM_PUF SHALL latch puf_sel and L, clear resp and chal, and go to SETTLE.
REQ-018 IDLE with start=1 and puf_sel>=NUM_PUF SHALL pulse err for one cycle, stay IDLE, and leave resp unchanged.
REQ-019 In SETTLE and SAMPLE, puf_en SHALL equal 1<<sel_latched; otherwise puf_en SHALL be 0.
REQ-020 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to SAMPLE.
REQ-021 SAMPLE SHALL last VOTE cycles, sampling puf_bit[sel] once per cycle and counting ones.
REQ-022 On the last SAMPLE cycle, the majority bit (ones > VOTE/2, including that cycle's sample) SHALL be shifted into resp LSB: resp <= {resp[RESP_W-2:0], maj}.
REQ-023 After REQ-022, if chal==L-1 the FSM SHALL go to SHIFT; otherwise chal SHALL increment and the FSM SHALL return to SETTLE.
REQ-024 SHIFT SHALL last L cycles with so_valid=1 and so=resp[L-1-k] in cycle k; outside SHIFT, so=0 and so_valid=0.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 Latency from the start-accept edge to done high SHALL be 1 + L*(SETTLE_CYC+VOTE) + L cycles.
REQ-029 resp SHALL hold its value after DONE until the next accepted start.
REQ-030 A length or puf_sel change while busy SHALL have no effect, because both are latched at accept.

Reset
REQ-031 Reset assertion SHALL force, asynchronously: state=IDLE; resp, chal, counters, puf_en, so, so_valid, busy, done and err all 0.
REQ-032 Reset asserted mid-operation SHALL abort the capture with no done pulse.
REQ-033 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-034 Package puf_pkg SHALL hold the FSM state enum, the length-decode function and the SELW helper.
REQ-035 A sub-module puf_vote_counter SHALL implement the VOTE-sample ones counter and majority output.
REQ-036 All counter widths SHALL be derived via $clog2 from the parameters; there SHALL be no hardcoded widths.

Verification (defaults unless stated)
REQ-037 puf_bit[2]=1 constant, puf_sel=2, length=0, start -> resp=8'hFF, so=eight 1s, done exactly 97 cycles after accept.
REQ-038 puf_bit[1]=chal[0], puf_sel=1, length=1 -> resp=16'h5555, so sequence 0,1,0,1,..., done after 1+16*11+16=193 cycles.
REQ-039 Constant-1 source with one sample per vote window forced to 0, length=3 -> resp=64'hFFFF_FFFF_FFFF_FFFF.
REQ-040 NUM_PUF=3 instance, puf_sel=3, start -> err pulse for one cycle, busy stays 0, resp unchanged.
REQ-041 Reset asserted during SAMPLE -> puf_en=0 and busy=0 without waiting for a clock edge, no done; a new start then completes normally.
REQ-042 start re-pulsed and puf_sel changed during SETTLE -> ignored; the capture completes on the originally latched source.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and elaboration helpers for the PUF multi-sampler.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Response length in bits for a 2-bit length code.
  function automatic int unsigned resp_len(input int unsigned resp_w, input logic [1:0] code);
    return resp_w >> (3 - 32'(code));
  endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// Counts ones over VOTE consecutive samples and reports the majority on the last one.
module puf_vote_counter #(
  parameter int unsigned VOTE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  input  logic bit_in,
  output logic last,
  output logic maj
);

  localparam int unsigned IW = (VOTE > 1) ? $clog2(VOTE) : 1;
  localparam int unsigned OW = $clog2(VOTE + 1);

  logic [IW-1:0] idx;
  logic [OW-1:0] ones;
  logic [OW:0]   total;

  assign last  = (idx == IW'(VOTE - 1));
  // Majority includes the sample presented in the final cycle.
  assign total = {1'b0, ones} + (OW + 1)'(bit_in);
  assign maj   = (total > (OW + 1)'(VOTE / 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx  <= '0;
      ones <= '0;
    end else if (sample) begin
      if (last) begin
        idx  <= '0;
        ones <= '0;
      end else begin
        idx  <= idx + 1'b1;
        ones <= ones + OW'(bit_in);
      end
    end
  end

endmodule

// File: rtl/puf_multi_sampler.sv
// Captures a PUF response bit by bit with settle time and majority voting, then streams it out.
module puf_multi_sampler
  import puf_pkg::*;
#(
  parameter int unsigned NUM_PUF    = 4,
  parameter int unsigned RESP_W     = 64,
  parameter int unsigned VOTE       = 3,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [sel_width(NUM_PUF)-1:0] puf_sel,
  input  logic [1:0]                    length,
  input  logic [NUM_PUF-1:0]            puf_bit,
  output logic [NUM_PUF-1:0]            puf_en,
  output logic [$clog2(RESP_W)-1:0]     chal,
  output logic [RESP_W-1:0]             resp,
  output logic                          so,
  output logic                          so_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int unsigned SELW = sel_width(NUM_PUF);
  localparam int unsigned NSEL = 2 ** SELW;
  localparam int unsigned CW   = $clog2(RESP_W);
  localparam int unsigned SW   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t          state, state_nx;
  logic [SELW-1:0] sel_q;
  logic [CW-1:0]   last_q, chal_q, shift_q;
  logic [SW-1:0]   settle_q;
  logic [RESP_W-1:0] resp_q;
  logic            err_q;
  logic [NSEL-1:0] sel_valid;
  logic            sel_ok, settle_end, shift_end, vote_last, maj;

  always_comb begin
    sel_valid = '0;
    for (int unsigned i = 0; i < NSEL; i++) sel_valid[i] = (i < NUM_PUF);
  end

  assign sel_ok     = sel_valid[puf_sel];
  assign settle_end = (settle_q == SW'(SETTLE_CYC - 1));
  assign shift_end  = (shift_q == last_q);

  puf_vote_counter #(.VOTE(VOTE)) u_vote (
    .clk    (clk),
    .reset  (reset),
    .sample (state == ST_SAMPLE),
    .bit_in (puf_bit[sel_q]),
    .last   (vote_last),
    .maj    (maj)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    puf_en   = '0;
    so       = 1'b0;
    so_valid = 1'b0;
    busy     = (state != ST_IDLE);
    done     = 1'b0;
    unique case (state)
      ST_IDLE:   if (start && sel_ok) state_nx = ST_SETTLE;
      ST_SETTLE: begin
        puf_en = NUM_PUF'(1) << sel_q;
        if (settle_end) state_nx = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        puf_en = NUM_PUF'(1) << sel_q;
        if (vote_last) state_nx = (chal_q == last_q) ? ST_SHIFT : ST_SETTLE;
      end
      ST_SHIFT: begin
        so_valid = 1'b1;
        // MSB first: cycle k emits resp[L-1-k], and L-1 is held in last_q.
        so       = resp_q[last_q - shift_q];
        if (shift_end) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q    <= '0;
      last_q   <= '0;
      chal_q   <= '0;
      shift_q  <= '0;
      settle_q <= '0;
      resp_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start && sel_ok) begin
            sel_q    <= puf_sel;
            last_q   <= CW'(resp_len(RESP_W, length) - 1);
            chal_q   <= '0;
            shift_q  <= '0;
            settle_q <= '0;
            resp_q   <= '0;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        ST_SETTLE: settle_q <= settle_end ? '0 : settle_q + 1'b1;
        ST_SAMPLE: begin
          if (vote_last) begin
            resp_q <= {resp_q[RESP_W-2:0], maj};
            if (chal_q != last_q) chal_q <= chal_q + 1'b1;
          end
        end
        ST_SHIFT: shift_q <= shift_end ? '0 : shift_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign chal = chal_q;
  assign resp = resp_q;
  assign err  = err_q;

endmodule
